// File: rtl/fpu_8_op_sequencer_if.sv
// Signal bundle between the FPU_8 op sequencer and its environment:
// command push port, FPU_8 core operand/result wires, result port and status.
interface fpu_8_op_sequencer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             CMD_VALID;
    logic             CMD_READY;
    logic [7:0]       CMD_A;
    logic [7:0]       CMD_B;
    logic [1:0]       CMD_OP;
    logic             CMD_RND;

    logic             FP_Start;
    logic [7:0]       OP_A;
    logic [7:0]       OP_B;
    logic [1:0]       FP_OPERATION;
    logic             FP_ROUND_MODE;
    logic [7:0]       OP_RESULT;
    logic             OP_IS_EXCEPTION;
    logic [1:0]       FP_Exception;

    logic             RES_VALID;
    logic             RES_READY;
    logic [7:0]       RES_DATA;
    logic             RES_EXC;
    logic [1:0]       RES_EXC_CODE;

    logic [3:0]       STICKY_EXC;
    logic             STICKY_CLR;
    logic             BUSY;
    logic [CNT_W-1:0] CMD_COUNT;

    modport slave (
        input  CMD_VALID, CMD_A, CMD_B, CMD_OP, CMD_RND,
        output CMD_READY,
        output FP_Start, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE,
        input  OP_RESULT, OP_IS_EXCEPTION, FP_Exception,
        output RES_VALID, RES_DATA, RES_EXC, RES_EXC_CODE,
        input  RES_READY,
        output STICKY_EXC, BUSY, CMD_COUNT,
        input  STICKY_CLR
    );

    modport master (
        output CMD_VALID, CMD_A, CMD_B, CMD_OP, CMD_RND,
        input  CMD_READY,
        input  FP_Start, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE,
        output OP_RESULT, OP_IS_EXCEPTION, FP_Exception,
        input  RES_VALID, RES_DATA, RES_EXC, RES_EXC_CODE,
        output RES_READY,
        input  STICKY_EXC, BUSY, CMD_COUNT,
        output STICKY_CLR
    );
endinterface

// File: rtl/fpu_8_op_sequencer.sv
// Command FIFO plus issue/wait/hold sequencer in front of the combinational
// FPU_8 core; captures results after FPU_LAT cycles and tracks sticky exceptions.
module fpu_8_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FPU_LAT    = 1
) (
    input logic                CLK,
    input logic                RST_N,
    fpu_8_op_sequencer_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(FPU_LAT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [LAT_W-1:0] LAT_C   = LAT_W'(FPU_LAT);

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic       rnd;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state, state_nxt;
    cmd_t             mem [FIFO_DEPTH];
    cmd_t             cur;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [LAT_W-1:0] wait_cnt;
    logic             push, pop, capture, fifo_ne;
    logic [7:0]       res_data;
    logic             res_exc;
    logic [1:0]       res_code;
    logic [3:0]       sticky, sticky_nxt;

    assign fifo_ne       = (count != '0);
    assign bus.CMD_READY = (count < DEPTH_C);
    assign push          = bus.CMD_VALID && bus.CMD_READY;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= '{a: bus.CMD_A, b: bus.CMD_B, op: bus.CMD_OP, rnd: bus.CMD_RND};
    end

    // Pop is only ever requested by the FSM, which checks fifo_ne first.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: if (fifo_ne) begin
                pop       = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: state_nxt = WAIT;
            WAIT: if (wait_cnt == LAT_W'(1)) begin
                capture   = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: if (bus.RES_READY) begin
                if (fifo_ne) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Set wins over clear so a same-cycle capture is never lost.
    always_comb begin
        sticky_nxt = bus.STICKY_CLR ? 4'b0000 : sticky;
        if (capture && bus.OP_IS_EXCEPTION) sticky_nxt[bus.FP_Exception] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur      <= '0;
            wait_cnt <= '0;
            res_data <= '0;
            res_exc  <= 1'b0;
            res_code <= '0;
            sticky   <= '0;
        end else begin
            if (pop) cur <= mem[rd_ptr];
            if (state == ISSUE)     wait_cnt <= LAT_C;
            else if (state == WAIT) wait_cnt <= wait_cnt - 1'b1;
            if (capture) begin
                res_data <= bus.OP_RESULT;
                res_exc  <= bus.OP_IS_EXCEPTION;
                res_code <= bus.FP_Exception;
            end
            sticky <= sticky_nxt;
        end
    end

    assign bus.FP_Start      = (state == ISSUE);
    assign bus.OP_A          = cur.a;
    assign bus.OP_B          = cur.b;
    assign bus.FP_OPERATION  = cur.op;
    assign bus.FP_ROUND_MODE = cur.rnd;
    assign bus.RES_VALID     = (state == HOLD);
    assign bus.RES_DATA      = res_data;
    assign bus.RES_EXC       = res_exc;
    assign bus.RES_EXC_CODE  = res_code;
    assign bus.STICKY_EXC    = sticky;
    assign bus.BUSY          = (state != IDLE) || fifo_ne;
    assign bus.CMD_COUNT     = count;
endmodule
